mux_arb_reg: RTL and testbench

Parametrised N-channel, W-bit registered bus multiplexer with a valid/ready handshake on every input channel and on the output. It is the next generation of the CPU's 2:1 select mux. It supports two modes: fixed selection (driven by a select input, as in the datapath muxes) and round-robin arbitration among requesting channels. It sits between multiple 16-bit producers (register file ports, ALU result, memory read data) and a single downstream consumer, and provides one cycle of registered latency with full throughput.

---
 rtl/mux_arb_reg_if.sv | 28 ++
 rtl/mux_arb_reg.sv | 88 ++++++++
 tb/tb_mux_arb_reg.sv | 233 +++++++++++++++++++++++
 3 files changed

// File: rtl/mux_arb_reg_if.sv
// Handshake bundle for mux_arb_reg: N valid/ready input channels, select/mode controls,
// and one registered valid/ready output channel.
interface mux_arb_reg_if #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic [CHANNELS*WIDTH-1:0] in_data;
  logic [CHANNELS-1:0]       in_valid;
  logic [CHANNELS-1:0]       in_ready;
  logic                      mode;
  logic [SEL_W-1:0]          sel;
  logic [WIDTH-1:0]          out_data;
  logic [SEL_W-1:0]          out_chan;
  logic                      out_valid;
  logic                      out_ready;

  modport master (
    output in_data, in_valid, mode, sel, out_ready,
    input  in_ready, out_data, out_chan, out_valid
  );

  modport slave (
    input  in_data, in_valid, mode, sel, out_ready,
    output in_ready, out_data, out_chan, out_valid
  );
endinterface

// File: rtl/mux_arb_reg.sv
// N:1 registered mux, fixed-select or round-robin; 1-cycle latency, full throughput.
// Backpressure: in_ready drops to all-zero while the held output word is stalled.
module mux_arb_reg #(
  parameter int WIDTH    = 16,
  parameter int CHANNELS = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  mux_arb_reg_if.slave bus
);
  localparam int SEL_W = (CHANNELS > 1) ? $clog2(CHANNELS) : 1;

  logic                 load_en;
  logic                 grant_vld;
  logic [SEL_W-1:0]     grant;
  logic                 xfer;
  logic [CHANNELS-1:0]  ready_vec;

  logic [WIDTH-1:0]     out_data_q, out_data_d;
  logic [SEL_W-1:0]     out_chan_q, out_chan_d;
  logic                 out_vld_q,  out_vld_d;
  logic [SEL_W-1:0]     rr_last_q,  rr_last_d;

  // An empty slot always accepts, so out_ready never reaches in_ready in that case.
  assign load_en = !out_vld_q | bus.out_ready;

  always_comb begin : grant_sel
    int idx;
    idx       = 0;
    grant     = '0;
    grant_vld = 1'b0;
    if (!bus.mode) begin
      grant     = bus.sel;
      grant_vld = (int'(bus.sel) < CHANNELS);
    end else begin
      // Walk the ring backwards so the last hit is the nearest channel after rr_last.
      for (int k = CHANNELS; k >= 1; k--) begin
        idx = int'(rr_last_q) + k;
        if (idx >= CHANNELS) idx = idx - CHANNELS;
        if (bus.in_valid[idx]) begin
          grant     = SEL_W'(idx);
          grant_vld = 1'b1;
        end
      end
    end
  end

  always_comb begin
    ready_vec = '0;
    if (grant_vld) ready_vec[grant] = load_en & rst_n;
  end

  assign xfer = grant_vld & load_en & bus.in_valid[grant];

  always_comb begin
    out_data_d = out_data_q;
    out_chan_d = out_chan_q;
    out_vld_d  = out_vld_q;
    rr_last_d  = rr_last_q;
    if (xfer) begin
      out_data_d = bus.in_data[int'(grant)*WIDTH +: WIDTH];
      out_chan_d = grant;
      out_vld_d  = 1'b1;
      if (bus.mode) rr_last_d = grant;
    end else if (bus.out_ready) begin
      out_vld_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_data_q <= '0;
      out_chan_q <= '0;
      out_vld_q  <= 1'b0;
      rr_last_q  <= SEL_W'(CHANNELS - 1);
    end else begin
      out_data_q <= out_data_d;
      out_chan_q <= out_chan_d;
      out_vld_q  <= out_vld_d;
      rr_last_q  <= rr_last_d;
    end
  end

  assign bus.in_ready  = ready_vec;
  assign bus.out_data  = out_data_q;
  assign bus.out_chan  = out_chan_q;
  assign bus.out_valid = out_vld_q;
endmodule

// File: tb/tb_mux_arb_reg.sv
// Bench for mux_arb_reg: directed plus random steps against a behavioural model (4 channels),
// with directed boundary checks on a 3-channel, 8-bit instance.
module tb_mux_arb_reg;
  localparam int W   = 16;
  localparam int CH  = 4;
  localparam int W3  = 8;
  localparam int CH3 = 3;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  mux_arb_reg_if #(.WIDTH(W),  .CHANNELS(CH))  b4 ();
  mux_arb_reg_if #(.WIDTH(W3), .CHANNELS(CH3)) b3 ();

  mux_arb_reg #(.WIDTH(W),  .CHANNELS(CH))  dut4 (.clk(clk), .rst_n(rst_n), .bus(b4));
  mux_arb_reg #(.WIDTH(W3), .CHANNELS(CH3)) dut3 (.clk(clk), .rst_n(rst_n), .bus(b3));

  logic [CH*W-1:0]   t_data;
  logic [CH-1:0]     t_valid;
  logic              t_mode;
  logic [1:0]        t_sel;
  logic              t_ordy;
  logic [CH3*W3-1:0] t3_data;
  logic [CH3-1:0]    t3_valid;
  logic              t3_mode;
  logic [1:0]        t3_sel;
  logic              t3_ordy;

  assign b4.in_data   = t_data;
  assign b4.in_valid  = t_valid;
  assign b4.mode      = t_mode;
  assign b4.sel       = t_sel;
  assign b4.out_ready = t_ordy;
  assign b3.in_data   = t3_data;
  assign b3.in_valid  = t3_valid;
  assign b3.mode      = t3_mode;
  assign b3.sel       = t3_sel;
  assign b3.out_ready = t3_ordy;

  int n_pass  = 0;
  int n_total = 0;
  int n_fail  = 0;

  // Reference model of the 4-channel instance: output slot contents and last RR winner.
  bit          m_vld;
  logic [15:0] m_data;
  int          m_chan;
  int          m_last;

  task automatic model_reset();
    m_vld  = 1'b0;
    m_data = '0;
    m_chan = 0;
    m_last = CH - 1;
  endtask

  function automatic int exp_grant();
    if (!t_mode) return (int'(t_sel) < CH) ? int'(t_sel) : -1;
    for (int k = 1; k <= CH; k++) begin
      if (t_valid[(m_last + k) % CH]) return (m_last + k) % CH;
    end
    return -1;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_total++;
    assert (obs === expv) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
    end
  endtask

  task automatic set_ch(input int i, input logic [15:0] v);
    t_data[i*W +: W] = v;
  endtask

  // One clock: check combinational in_ready, advance the model over the edge, check the slot.
  task automatic step(input string tag);
    int            g;
    logic [CH-1:0] er;
    bit            x;
    #1;
    g  = exp_grant();
    er = (g >= 0 && (!m_vld || t_ordy)) ? CH'(1 << g) : '0;
    chk({tag, ".in_ready"}, 32'(b4.in_ready), 32'(er));
    x  = (er != '0) && t_valid[g];
    @(posedge clk);
    if (x) begin
      m_vld  = 1'b1;
      m_data = t_data[g*W +: W];
      m_chan = g;
      if (t_mode) m_last = g;
    end else if (m_vld && t_ordy) begin
      m_vld = 1'b0;
    end
    #1;
    chk({tag, ".out_valid"}, 32'(b4.out_valid), 32'(m_vld));
    chk({tag, ".out_data"},  32'(b4.out_data),  32'(m_data));
    chk({tag, ".out_chan"},  32'(b4.out_chan),  32'(m_chan));
  endtask

  initial begin
    int seq4[6]  = '{0, 1, 2, 3, 0, 1};
    int alt[4]   = '{3, 1, 3, 1};
    int seq3[4]  = '{0, 1, 2, 0};

    rst_n    = 1'b0;
    t_data   = '0;
    t_valid  = '0;
    t_mode   = 1'b0;
    t_sel    = 2'd0;
    t_ordy   = 1'b0;
    t3_data  = '0;
    t3_valid = '0;
    t3_mode  = 1'b0;
    t3_sel   = 2'd0;
    t3_ordy  = 1'b1;
    model_reset();

    #12;
    chk("rst.out_valid", 32'(b4.out_valid), 32'd0);
    chk("rst.out_data",  32'(b4.out_data),  32'd0);
    chk("rst.out_chan",  32'(b4.out_chan),  32'd0);
    chk("rst.in_ready",  32'(b4.in_ready),  32'd0);
    chk("rst3.in_ready", 32'(b3.in_ready),  32'd0);
    @(negedge clk);
    rst_n = 1'b1;

    // Fixed select of channel 2, back-to-back words with no gap.
    t_mode = 1'b0; t_sel = 2'd2; t_valid = 4'b1111; t_ordy = 1'b1;
    for (int i = 0; i < CH; i++) set_ch(i, 16'(32'h0F00 + i));
    set_ch(2, 16'hBEEF);
    for (int k = 0; k < 3; k++) begin
      step("fix");
      chk("fix.beef", 32'(b4.out_data), 32'h0000BEEF);
    end

    // Round-robin over four requesters.
    t_mode = 1'b1;
    for (int i = 0; i < CH; i++) set_ch(i, 16'(32'h1000 + i));
    for (int k = 0; k < 6; k++) begin
      step("rr4");
      chk("rr4.seq",  32'(b4.out_chan), 32'(seq4[k]));
      chk("rr4.data", 32'(b4.out_data), 32'h1000 + 32'(seq4[k]));
    end

    // Two sparse requesters alternate, then a lone requester wins every cycle.
    t_valid = 4'b1010;
    for (int k = 0; k < 4; k++) begin
      step("alt");
      chk("alt.seq", 32'(b4.out_chan), 32'(alt[k]));
    end
    t_valid = 4'b0010;
    for (int k = 0; k < 3; k++) begin
      step("solo");
      chk("solo.seq", 32'(b4.out_chan), 32'd1);
    end

    // Backpressure holds 0x00AA, then drain and reload share one edge.
    t_mode = 1'b0; t_sel = 2'd0; t_valid = 4'b0001; set_ch(0, 16'h00AA);
    step("bp.load");
    t_ordy = 1'b0; t_valid = 4'b1111; set_ch(0, 16'h1234);
    for (int k = 0; k < 5; k++) begin
      step("bp.hold");
      chk("bp.hold_data", 32'(b4.out_data), 32'h000000AA);
    end
    t_ordy = 1'b1;
    step("bp.reload");
    chk("bp.reload_data", 32'(b4.out_data), 32'h00001234);

    // Random traffic against the model.
    for (int k = 0; k < 300; k++) begin
      t_data  = {$urandom, $urandom};
      t_mode  = 1'($urandom_range(0, 1));
      t_sel   = 2'($urandom_range(0, 3));
      t_valid = 4'($urandom_range(0, 15));
      t_ordy  = ($urandom_range(0, 3) != 0);
      step("rnd");
    end

    // Reset while a word is held discards it; round-robin restarts at channel 0.
    t_mode = 1'b1; t_valid = 4'b1111; t_ordy = 1'b1;
    for (int i = 0; i < CH; i++) set_ch(i, 16'(32'h2000 + i));
    step("pre_rst");
    step("pre_rst");
    t_ordy = 1'b0;
    step("pre_rst.hold");
    #2;
    rst_n = 1'b0;
    #1;
    chk("mrst.out_valid", 32'(b4.out_valid), 32'd0);
    chk("mrst.out_data",  32'(b4.out_data),  32'd0);
    chk("mrst.out_chan",  32'(b4.out_chan),  32'd0);
    chk("mrst.in_ready",  32'(b4.in_ready),  32'd0);
    model_reset();
    @(negedge clk);
    rst_n  = 1'b1;
    t_ordy = 1'b1;
    step("post_rst");
    chk("post_rst.first", 32'(b4.out_chan), 32'd0);
    step("post_rst");

    // 3-channel instance: out-of-range select grants nothing, then RR wraps after channel 2.
    t3_mode = 1'b0; t3_sel = 2'd3; t3_valid = 3'b111; t3_ordy = 1'b1;
    for (int i = 0; i < CH3; i++) t3_data[i*W3 +: W3] = 8'(32'h10 + i);
    #1;
    chk("c3.sel3_ready", 32'(b3.in_ready), 32'd0);
    @(posedge clk);
    #1;
    chk("c3.sel3_noload", 32'(b3.out_valid), 32'd0);
    t3_mode = 1'b1;
    #1;
    chk("c3.rr_ready0", 32'(b3.in_ready), 32'b001);
    for (int k = 0; k < 4; k++) begin
      @(posedge clk);
      #1;
      chk("c3.rr_valid", 32'(b3.out_valid), 32'd1);
      chk("c3.rr_chan",  32'(b3.out_chan),  32'(seq3[k]));
      chk("c3.rr_data",  32'(b3.out_data),  32'h10 + 32'(seq3[k]));
    end

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog observed=timeout expected=finish");
    $fatal(1, "watchdog expired");
  end
endmodule
